// File: rtl/eq_gain_scheduler_if.sv
// Handshake and configuration bundle for the equalizer gain/mix scheduler.
// The master side is the band filter bank plus the gain configuration source.
interface eq_gain_scheduler_if;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       data_in;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic [7:0]         cfg_gain;
    logic signed [20:0] data_out;
    logic               out_valid;
    logic               busy;

    modport master (
        output in_valid, data_in, cfg_we, cfg_addr, cfg_gain,
        input  in_ready, data_out, out_valid, busy
    );

    modport slave (
        input  in_valid, data_in, cfg_we, cfg_addr, cfg_gain,
        output in_ready, data_out, out_valid, busy
    );
endinterface

// File: rtl/eq_gain_scheduler.sv
// Sequenced per-band gain and mix for the 8-band equalizer output stage.
// One shared multiplier walks bands 0..7 and accumulates Q2.6-scaled terms.
module eq_gain_scheduler #(
    parameter int NBANDS    = 8,
    parameter int GAIN_FRAC = 6
) (
    input logic                clk,
    input logic                rst_n,
    eq_gain_scheduler_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] UNITY = 8'(1 << GAIN_FRAC);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic signed [20:0] acc_q, acc_d;
    logic signed [20:0] data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic [127:0]       frame_q, frame_d;
    logic [7:0]         shadow_q [NBANDS];
    logic [7:0]         shadow_d [NBANDS];
    logic [7:0]         active_q [NBANDS];
    logic [7:0]         active_d [NBANDS];

    // The single shared multiplier: current band sample times zero-extended gain.
    logic signed [15:0] sample;
    logic signed [8:0]  gain_s;
    logic signed [24:0] product;
    logic signed [20:0] term;

    assign sample  = frame_q[{idx_q, 4'b0000} +: 16];
    assign gain_s  = {1'b0, active_q[idx_q]};
    assign product = sample * gain_s;
    assign term    = 21'(product >>> GAIN_FRAC);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        frame_d     = frame_q;
        shadow_d    = shadow_q;
        active_d    = active_q;

        if (bus.cfg_we) begin
            shadow_d[bus.cfg_addr] = bus.cfg_gain;
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    frame_d  = bus.data_in;
                    active_d = shadow_q;  // old shadow: a same-edge cfg write waits for the next frame
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + term;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    data_out_d  = acc_q + term;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            // NOTE: the gain banks are small register arrays that must come out of reset at unity, so they are reset.
            for (int k = 0; k < NBANDS; k++) begin
                shadow_q[k] <= UNITY;
                active_q[k] <= UNITY;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    // Frame samples are only read in RUN after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/eq_gain_scheduler.md
# eq_gain_scheduler

Time-multiplexed per-band gain and mix controller for the 8-band equalizer output stage. It accepts one frame of eight signed 16-bit band samples, drives a single shared multiplier through the bands in order 0..7, and applies a runtime-configurable unsigned gain to each band. The scaled products are accumulated into one 21-bit mixed sample. It sits between the band filter bank and the output path, and it replaces fixed unity-gain summation with a sequenced, gain-controlled mix.

## Interface

Parameters:
- NBANDS, 8, number of bands; fixed, and the RTL is not required to support other values.
- GAIN_FRAC, 6, number of fractional bits in the gain (Q2.6, so 64 = unity).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  band frame valid.
- in_ready  out  1  block can accept a frame; high only in IDLE.
- data_in  in  128  band samples; band k is data_in[16k+15:16k], signed two's complement.
- cfg_we  in  1  gain write strobe.
- cfg_addr  in  3  band index for the gain write.
- cfg_gain  in  8  unsigned gain, Q2.6, range 0..255 (0 to 3.984).
- data_out  out  21  signed mixed sample, registered.
- out_valid  out  1  one-cycle pulse when data_out is updated.
- busy  out  1  high while a frame is in progress (RUN state).

## Operation

- Gain banks:
  - shadow[0..7] is written by cfg_we at any time; the write lands on the edge.
  - active[0..7] is loaded from shadow on the frame-capture edge.
  - A cfg write on the same edge as a capture is not seen by that frame; it applies to the next frame.
  - Reset value of both banks is 64 (unity).
- FSM has two states:
  - IDLE: in_ready=1. When in_valid&in_ready, latch data_in into the frame register, copy shadow to active, clear the accumulator, set idx=0, go to RUN.
  - RUN: each cycle, acc += term(idx) and idx++. On the cycle with idx=7, data_out <= acc + term(7), out_valid <= 1, go to IDLE.
- Term arithmetic:
  - term(k) = (sample_k × {1'b0, active[k]}) >>> GAIN_FRAC.
  - The product is a 25-bit signed value, shifted arithmetically, which truncates toward −∞.
  - Each term fits 18-bit signed. Range is −130560..+130556.
- Accumulation:
  - The accumulator and data_out are 21-bit signed.
  - The full-scale sum (8 × term) stays within ±1,044,480 and cannot overflow, so no saturation is needed.
- Exactly one multiplier is instantiated.
- in_valid while not ready: the frame is not taken. The upstream block must hold it until in_ready.
- There is no downstream backpressure. out_valid is a pulse, and data_out holds its value until the next frame completes.
- Reset mid-frame: everything clears immediately. The in-flight frame is discarded, no out_valid is produced, and gains return to 64.

## Timing

- Reset values: data_out=0, out_valid=0, busy=0, in_ready=1, state=IDLE, idx=0, accumulator=0, both gain banks=64.
- A capture at edge T produces RUN accumulation edges T+1..T+8. data_out and out_valid update at edge T+8; out_valid is high for the cycle after T+8 only.
- in_ready is combinational from state; it drops the cycle after capture and returns after edge T+8.
- The next capture can happen at the earliest at edge T+9. Throughput is one frame per 9 cycles.
- busy is high for the 8 RUN cycles.
- A cfg write during RUN does not affect the frame in flight.

## Test plan

- Reset then all bands = 1000 with default gains → out_valid 9 cycles after in_valid rise, data_out = 8000; in_ready low for exactly 8 cycles.
- Write gain[3]=128 and gain[5]=0, then a frame with all bands = 1000 → data_out = 8000 + 1000 − 1000 = 8000. Then band3=500, band5=700, other bands 0 → 1000.
- Rounding and extremes:
  - band0 = −1, gain[0]=1, other bands 0 → data_out = −1.
  - all bands 32767 with all gains 255 → 1,044,448.
  - all bands −32768 with all gains 255 → −1,044,480.
- Write gain[0]=0 on the capture edge of a frame with band0=1000 and other bands 0 → that frame outputs 1000. The next identical frame outputs 0.
- Hold in_valid high continuously with changing data → one frame accepted every 9 cycles. No frame is lost or duplicated, and each data_out matches its own frame.
- Assert rst_n low at RUN idx=4 → data_out=0 and out_valid=0 immediately, no pulse follows, and gains read back as unity on the next frame (all 1000 → 8000).
